// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the fetch/execute sequencer of the 9-bit core.
package seq_pkg;

    localparam int DEF_PC_W    = 10;
    localparam int DEF_INSTR_W = 9;
    localparam int DEF_CNT_W   = 16;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the sequencer (master) and ROM / decoder / harness (slave).
interface instr_sequencer_if
    import seq_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int CNT_W   = DEF_CNT_W
);

    logic               start;
    logic [PC_W-1:0]    start_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               branch;
    logic               mem_op;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    prog_ctr;
    logic [INSTR_W-1:0] instr_q;
    logic               reg_we_en;
    logic               mem_we_en;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  start, start_addr, rom_data, branch, mem_op, target,
        output prog_ctr, instr_q, reg_we_en, mem_we_en, busy, done, retired
    );

    modport slave (
        output start, start_addr, rom_data, branch, mem_op, target,
        input  prog_ctr, instr_q, reg_we_en, mem_we_en, busy, done, retired
    );

endinterface

// File: rtl/instr_sequencer_prog_counter.sv
// Program counter: load > branch > increment > hold; increment wraps.
module prog_counter
    import seq_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    input  logic            take,
    input  logic [PC_W-1:0] target,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= '0;
        else if (load)
            pc <= load_addr;
        else if (take)
            pc <= target;
        else if (inc)
            pc <= pc + PC_W'(1);
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC and IR, gates write strobes
// to one commit cycle per instruction, and runs the start/done handshake.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | ROM addressed by prog_ctr, instr_q loads at the next edge
// EXEC  | decode; commit non-memory ops, detect HALT, or defer to MEM
// MEM   | commit cycle for load/store/lb
// DONE  | HALT reached; PC and retired held until the next start
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    instr_sequencer_if.master bus
);

    seq_state_t         state_q, state_d;
    logic [INSTR_W-1:0] ir_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PC_W-1:0]    pc;

    logic pc_load, pc_take, pc_inc;
    logic ir_load, retire, cnt_clr, we_en;
    logic is_halt;

    assign is_halt = (ir_q == INSTR_W'(HALT_INSTR));

    prog_counter #(.PC_W(PC_W)) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .load_addr (bus.start_addr),
        .take      (pc_take),
        .target    (bus.target),
        .inc       (pc_inc),
        .pc        (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load)
                ir_q <= bus.rom_data;
            if (cnt_clr)
                cnt_q <= '0;
            else if (retire && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_load = 1'b0;
        pc_take = 1'b0;
        pc_inc  = 1'b0;
        ir_load = 1'b0;
        retire  = 1'b0;
        cnt_clr = 1'b0;
        we_en   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    pc_load = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_halt) begin
                    state_d = S_DONE;
                end else if (!bus.mem_op) begin
                    we_en   = 1'b1;
                    pc_take = bus.branch;
                    pc_inc  = !bus.branch;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    // address/data operands stay stable into MEM since nothing changes here
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                we_en   = 1'b1;
                pc_inc  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.prog_ctr  = pc;
    assign bus.instr_q   = ir_q;
    assign bus.retired   = cnt_q;
    assign bus.reg_we_en = we_en;
    assign bus.mem_we_en = we_en;
    assign bus.busy      = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
    assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed programs plus random programs, each
// checked against a program-level reference model of the sequencer.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    localparam logic [8:0] OP_ADD   = 9'h005;
    localparam logic [8:0] OP_LOAD  = 9'h100;
    localparam logic [8:0] OP_BEQ_T = 9'h1C0;
    localparam logic [8:0] OP_BEQ_N = 9'h180;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instr_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

    instr_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [1024];
    logic [9:0] lut [16];

    int n_chk  = 0;
    int n_fail = 0;

    logic       mon_en   = 1'b0;
    logic [9:0] obs_q [$];
    int         n_mem_we = 0;

    logic [9:0] exp_q [$];
    int         exp_edges;
    logic [9:0] exp_pc;
    int         exp_ret;

    // Decoder stand-in: [8:7]=10 is a memory op, [8:7]=11 with [6] set is a taken branch.
    function automatic logic f_mem(logic [8:0] i);
        return i[8:7] == 2'b10;
    endfunction

    function automatic logic f_br(logic [8:0] i);
        return (i[8:7] == 2'b11) && i[6];
    endfunction

    assign bus.mem_op = f_mem(bus.instr_q);
    assign bus.branch = f_br(bus.instr_q);
    assign bus.target = lut[bus.instr_q[3:0]];

    // ROM registered on the falling edge so the word at prog_ctr is ready by the end of FETCH.
    always @(negedge clk) bus.rom_data <= rom[bus.prog_ctr];

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.reg_we_en) obs_q.push_back(bus.prog_ctr);
            if (bus.mem_we_en) n_mem_we++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = HALT_INSTR;
    endtask

    // Walks the program instruction by instruction: commit PCs, cycle total, final PC, count.
    task automatic model(input logic [9:0] sa);
        logic [9:0] pc;
        logic [8:0] ins;
        pc = sa;
        exp_q.delete();
        exp_edges = 0;
        exp_ret   = 0;
        for (int n = 0; n < 300; n++) begin
            ins = rom[pc];
            if (ins == HALT_INSTR) begin
                exp_edges += 2;
                break;
            end
            exp_q.push_back(pc);
            if (exp_ret < 65535) exp_ret++;
            if (f_mem(ins)) begin
                exp_edges += 3;
                pc = pc + 10'd1;
            end else begin
                exp_edges += 2;
                pc = f_br(ins) ? lut[ins[3:0]] : pc + 10'd1;
            end
        end
        exp_pc = pc;
    endtask

    // Called at a falling edge; start is sampled at the following rising edge.
    task automatic run(input logic [9:0] sa, input string tag, input bit noise);
        int edges;
        bit got;
        model(sa);
        obs_q.delete();
        n_mem_we = 0;
        mon_en = 1'b1;
        bus.start = 1'b1;
        bus.start_addr = sa;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".busy_at_fetch"}, 32'(bus.busy), 32'd1);
        chk({tag, ".first_pc"}, 32'(bus.prog_ctr), 32'(sa));
        chk({tag, ".retired_clr"}, 32'(bus.retired), 32'd0);
        edges = 0;
        got = 1'b0;
        while (!got && edges < 500) begin
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.start_addr = 10'($urandom);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        mon_en = 1'b0;
        chk({tag, ".done_seen"}, 32'(got), 32'd1);
        chk({tag, ".cycles"}, 32'(edges), 32'(exp_edges));
        chk({tag, ".final_pc"}, 32'(bus.prog_ctr), 32'(exp_pc));
        chk({tag, ".retired"}, 32'(bus.retired), 32'(exp_ret));
        chk({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
        chk({tag, ".n_reg_we"}, 32'(obs_q.size()), 32'(exp_q.size()));
        chk({tag, ".n_mem_we"}, 32'(n_mem_we), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, ".commit_pc"}, 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] sa, t, d;
        int len;
        logic [8:0] r;

        bus.start = 1'b0;
        bus.start_addr = '0;
        clear_rom();
        for (int j = 0; j < 16; j++) lut[j] = 10'($urandom);

        repeat (3) @(negedge clk);
        chk("rst.pc", 32'(bus.prog_ctr), 32'd0);
        chk("rst.ir", 32'(bus.instr_q), 32'd0);
        chk("rst.retired", 32'(bus.retired), 32'd0);
        chk("rst.flags", 32'({bus.reg_we_en, bus.mem_we_en, bus.busy, bus.done}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Abort in the commit cycle of an add.
        rom[10'h040] = OP_ADD;
        rom[10'h041] = OP_ADD;
        bus.start = 1'b1;
        bus.start_addr = 10'h040;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort.we_before", 32'(bus.reg_we_en), 32'd1);
        #1 reset = 1'b1;
        #1;
        obs_q.delete();
        n_mem_we = 0;
        mon_en = 1'b1;
        chk("abort.flags", 32'({bus.reg_we_en, bus.mem_we_en, bus.busy, bus.done}), 32'd0);
        chk("abort.pc", 32'(bus.prog_ctr), 32'd0);
        chk("abort.ir", 32'(bus.instr_q), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        chk("abort.no_writes", 32'(obs_q.size() + n_mem_we), 32'd0);
        chk("abort.idle", 32'({bus.busy, bus.done}), 32'd0);
        chk("abort.pc_after", 32'(bus.prog_ctr), 32'd0);
        chk("abort.retired", 32'(bus.retired), 32'd0);
        clear_rom();

        rom[10'h010] = OP_ADD;
        rom[10'h011] = OP_ADD;
        run(10'h010, "addx2", 1'b0);
        chk("addx2.lit_cycles", 32'(exp_edges), 32'd6);
        chk("addx2.lit_pc", 32'(bus.prog_ctr), 32'h012);
        chk("addx2.lit_retired", 32'(bus.retired), 32'd2);
        chk("addx2.halt_ir", 32'(bus.instr_q), 32'(HALT_INSTR));
        clear_rom();

        rom[10'h020] = OP_LOAD;
        run(10'h020, "load", 1'b0);
        chk("load.lit_pc", 32'(bus.prog_ctr), 32'h021);
        clear_rom();

        lut[5] = 10'h055;
        rom[10'h030] = OP_BEQ_T | 9'h005;
        run(10'h030, "beq_taken", 1'b0);
        chk("beq_taken.lit_pc", 32'(bus.prog_ctr), 32'h055);
        rom[10'h030] = OP_BEQ_N | 9'h005;
        run(10'h030, "beq_not", 1'b0);
        chk("beq_not.lit_pc", 32'(bus.prog_ctr), 32'h031);
        clear_rom();

        rom[10'h3FF] = OP_ADD;
        run(10'h3FF, "wrap", 1'b1);
        chk("wrap.lit_pc", 32'(bus.prog_ctr), 32'h000);

        repeat (4) @(negedge clk);
        chk("hold.done", 32'(bus.done), 32'd1);
        chk("hold.pc", 32'(bus.prog_ctr), 32'h000);
        chk("hold.retired", 32'(bus.retired), 32'd1);
        clear_rom();

        rom[10'h100] = OP_ADD;
        rom[10'h101] = OP_LOAD;
        run(10'h100, "restart", 1'b1);
        chk("restart.lit_retired", 32'(bus.retired), 32'd2);

        for (int it = 0; it < 25; it++) begin
            clear_rom();
            sa = 10'($urandom);
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                r = 9'($urandom);
                if (r == HALT_INSTR) r = OP_ADD;
                rom[sa + 10'(i)] = r;
            end
            // Branch targets land outside the program so every run reaches a HALT.
            for (int j = 0; j < 16; j++) begin
                do begin
                    t = 10'($urandom);
                    d = t - sa;
                end while (d <= 10'(len));
                lut[j] = t;
            end
            run(sa, "rand", 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/execute sequencer for the 9-bit-instruction core. It owns the program counter and the instruction register, and steps each instruction through fetch, execute and an optional memory cycle. It gates the control decoder's register-write and memory-write strobes so they take effect exactly once per instruction. It also provides the start/done handshake to the test harness.

## Interface
- PC_W, 10, program-counter / instruction-ROM address width
- INSTR_W, 9, instruction width
- CNT_W, 16, retired-instruction counter width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces reset values below
- start  in  1  level sampled in IDLE/DONE; begins a run at start_addr
- start_addr  in  PC_W  first instruction address, sampled with start
- rom_data  in  INSTR_W  instruction ROM output; ROM is synchronous, 1-cycle read latency from prog_ctr
- branch  in  1  decoder branch-taken, combinational from instr_q and register data
- mem_op  in  1  decoder flag: instr_q is load, store or lb (touches data memory)
- target  in  PC_W  absolute branch target from the branch LUT, indexed by instr_q[3:0]
- prog_ctr  out  PC_W  current PC, drives ROM address
- instr_q  out  INSTR_W  latched instruction, feeds the decoder
- reg_we_en  out  1  AND-ed with decoder RegWrite at the register file
- mem_we_en  out  1  AND-ed with decoder MemWrite at data memory
- busy  out  1  high in FETCH/EXEC/MEM
- done  out  1  high in DONE
- retired  out  CNT_W  instructions committed in current run

## Operation
- States: IDLE, FETCH, EXEC, MEM, DONE.
- IDLE/DONE with start=1: PC <= start_addr, retired <= 0, go FETCH. start is ignored in all other states.
- FETCH: ROM reads at prog_ctr. Next edge: instr_q <= rom_data, go EXEC.
- EXEC with instr_q == HALT (9'h1FF): no enables asserted, PC held, retired unchanged, go DONE.
- EXEC with mem_op=0 (commit cycle): reg_we_en=mem_we_en=1. PC <= branch ? target : PC+1. retired += 1. Go FETCH.
- EXEC with mem_op=1: both enables 0. Go MEM. The memory address and store data stay stable because instr_q and the registers are unchanged.
- MEM (commit cycle): reg_we_en=mem_we_en=1 so load data lands from synchronous memory. PC <= PC+1, with branch ignored. retired += 1. Go FETCH.
- PC+1 wraps modulo 2^PC_W: 0x3FF goes to 0x000.
- retired saturates at all-ones.
- The enables are high only in commit cycles, so there is exactly one write per instruction.
- DONE holds until start; PC and retired stay readable.

## Timing
- Reset values: state IDLE, prog_ctr=0, instr_q=0, retired=0. reg_we_en, mem_we_en, busy and done are all 0.
- Reset mid-run aborts immediately with no further writes.
- Enables, busy and done are decoded from the state register (Moore), except that the EXEC enables also depend on instr_q and mem_op.
- Non-memory instruction: 2 cycles (FETCH, EXEC). Memory instruction: 3 cycles (FETCH, EXEC, MEM).
- start sampled at edge k: FETCH in cycle k+1, first commit no earlier than k+2.
- Halt fetched at FETCH in cycle n: EXEC in n+1, done=1 from n+2.
- branch and target are sampled only at the EXEC commit edge. Values in other cycles are don't-care.

## Structure
- Package seq_pkg holds:
  - the state enum (seq_state_t) for IDLE/FETCH/EXEC/MEM/DONE
  - the HALT_INSTR constant, 9'h1FF
  - the default PC_W
- One natural sub-module is prog_counter. It holds the PC register with priority load (start_addr) > branch (target) > increment > hold, plus async reset.

## Test plan
- Reset mid-EXEC of an add, then release: all outputs at reset values, no reg_we_en pulse, state IDLE.
- start with start_addr=0x010; ROM holds add, add, HALT: PCs 0x010, 0x011, 0x012; reg_we_en pulses twice; done high 6 cycles after start; retired=2.
- Load at 0x020: EXEC has enables 0, MEM has enables 1; next FETCH at 0x021; instruction takes 3 cycles.
- beq with branch=1 and target=0x055 at 0x030: next prog_ctr=0x055. Same instruction with branch=0: next prog_ctr=0x031.
- start_addr=0x3FF holding a non-branch add: next PC=0x000 (wrap). start pulsed while busy: no effect.
- DONE held, then start with start_addr=0x100: retired cleared, busy re-asserted, first FETCH at 0x100.
